// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, tick-based debounce, one-hot press pulses plus collision flag.
// Define AUTO_REPEAT_EN to build the shared UP/DOWN auto-repeat FSM.
module button_conditioner #(
    parameter int unsigned N_BTN          = 5,
    parameter int unsigned DEBOUNCE_TICKS = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned      REPEAT_DELAY  = 100,
    parameter int unsigned      REPEAT_PERIOD = 20,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(5'b00011)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_level,
    output logic             collision
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] edge_q, edge_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] edge_rest;
    logic             coll_q;
    logic             single;
    logic             multi;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        edge_d = level_d & ~level_q;
    end

    // Clearing the lowest set bit leaves a non-zero value only when two or more edges coincide.
    assign edge_rest = edge_q & (edge_q - N_BTN'(1));
    assign single    = (edge_q != '0) && (edge_rest == '0);
    assign multi     = (edge_rest != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            edge_q  <= '0;
            pulse_q <= '0;
            coll_q  <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            edge_q  <= edge_d;
            pulse_q <= pulse_d;
            coll_q  <= multi;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W = $clog2(RMAX + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] RPT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [N_BTN-1:0]  hsel_q, hsel_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    always_comb begin
        state_d = state_q;
        hsel_d  = hsel_q;
        rcnt_d  = rcnt_q;
        pulse_d = '0;
        // A fresh single press always wins over a pending repeat.
        if (single) begin
            pulse_d = edge_q;
            if ((edge_q & REPEAT_MASK) != '0) begin
                state_d = HOLD;
                hsel_d  = edge_q;
                rcnt_d  = '0;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q != IDLE) begin
            if (((level_q & hsel_q) == '0) || ((level_q & ~hsel_q) != '0)) begin
                state_d = IDLE;
            end else if (tick) begin
                if (state_q == HOLD && rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
                    pulse_d = hsel_q;
                    rcnt_d  = '0;
                    state_d = RPT;
                end else if (state_q == RPT && rcnt_q == RCNT_W'(REPEAT_PERIOD - 1)) begin
                    pulse_d = hsel_q;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hsel_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hsel_q  <= hsel_d;
            rcnt_q  <= rcnt_d;
        end
    end
`else
    always_comb begin
        pulse_d = single ? edge_q : '0;
    end
`endif

    assign btn_pulse = pulse_q;
    assign btn_level = level_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: tick every 4 clk, per-tick behavioural model of debounce,
// press arbitration and auto-repeat, checked on every clock.
module tb_button_conditioner;
    localparam int unsigned DEB     = 4;
    localparam int unsigned RDELAY  = 100;
    localparam int unsigned RPERIOD = 20;
    localparam logic [4:0]  RMASK   = 5'b00011;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [4:0] btn_raw;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;
    logic       collision;

    int vectors     = 0;
    int miscompares = 0;

    // Model state, advanced once per tick.
    logic [4:0] m_level;
    int         m_cnt [5];
    bit         hold_on;
    logic [4:0] hold_mask;
    int         hold_p;
    int         tick_no;
    int         pulse_seen;
    int         coll_seen;

    button_conditioner dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_raw   (btn_raw),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .collision (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tally();
        if (btn_pulse != 5'b0) pulse_seen++;
        if (collision) coll_seen++;
    endtask

    task automatic model_clear();
        m_level = '0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        hold_on = 1'b0;
    endtask

    // One tick period: tick edge, then three quiet edges. raw_next and reset land after the tick.
    task automatic period(input logic [4:0] raw_next, input bit rst);
        logic [4:0] old;
        logic [4:0] nl;
        logic [4:0] rises;
        logic [4:0] exp_rep;
        logic [4:0] exp_press;
        logic       exp_coll;
        int         d;

        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        tick_no++;

        old     = m_level;
        nl      = m_level;
        exp_rep = '0;
        for (int i = 0; i < 5; i++) begin
            if (btn_raw[i] == m_level[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == DEB) begin
                    nl[i]    = btn_raw[i];
                    m_cnt[i] = 0;
                end
            end
        end
        if (hold_on) begin
            if (old != hold_mask) begin
                hold_on = 1'b0;
            end else begin
                d = tick_no - hold_p;
                if (d == RDELAY || (d > RDELAY && (d - RDELAY) % RPERIOD == 0)) exp_rep = hold_mask;
            end
        end
        check("pulse_at_tick", btn_pulse, exp_rep);
        check("level_at_tick", btn_level, nl);
        check("coll_at_tick", 5'(collision), 5'b0);
        tally();
        m_level = nl;
        rises   = nl & ~old;

        btn_raw = raw_next;
        reset   = !rst;
        @(posedge clk);
        #1;
        reset = 1'b1;
        if (rst) begin
            model_clear();
            exp_press = '0;
            exp_coll  = 1'b0;
        end else begin
            exp_press = '0;
            exp_coll  = 1'b0;
            if ($countones(rises) == 1) begin
                exp_press = rises;
                if (AUTO && (rises & RMASK) != 5'b0) begin
                    hold_on   = 1'b1;
                    hold_mask = rises;
                    hold_p    = tick_no;
                end else begin
                    hold_on = 1'b0;
                end
            end else if ($countones(rises) > 1) begin
                exp_coll = 1'b1;
            end
        end
        check("press_pulse", btn_pulse, exp_press);
        check("press_coll", 5'(collision), 5'(exp_coll));
        check("press_level", btn_level, m_level);
        tally();

        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            check("quiet_pulse", btn_pulse, 5'b0);
            check("quiet_coll", 5'(collision), 5'b0);
            tally();
        end
    endtask

    task automatic hold(input logic [4:0] raw, input int n);
        for (int k = 0; k < n; k++) period(raw, 1'b0);
    endtask

    initial begin
        logic [4:0] pat;
        int         len;
        int         r;
        bit         rst;

        reset   = 1'b0;
        tick    = 1'b0;
        btn_raw = '0;
        tick_no = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulse", btn_pulse, 5'b0);
        check("reset_level", btn_level, 5'b0);
        check("reset_coll", 5'(collision), 5'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single UP press.
        pulse_seen = 0;
        hold(5'b00001, 10);
        check("t1_level", btn_level, 5'b00001);
        hold(5'b00000, 8);
        check_int("t1_pulses", pulse_seen, 1);

        // Short glitch on C is ignored.
        pulse_seen = 0;
        hold(5'b10000, 3);
        hold(5'b00000, 8);
        check_int("t2_pulses", pulse_seen, 0);

        // Simultaneous U and C presses collide.
        pulse_seen = 0;
        coll_seen  = 0;
        hold(5'b10001, 10);
        hold(5'b00000, 8);
        check_int("t3_pulses", pulse_seen, 0);
        check_int("t3_coll", coll_seen, 1);

        // DOWN held long enough for five repeats.
        pulse_seen = 0;
        hold(5'b00010, 190);
        hold(5'b00000, 10);
        check_int("t4_pulses", pulse_seen, AUTO ? 6 : 1);

        // C is not repeatable.
        pulse_seen = 0;
        hold(5'b10000, 200);
        hold(5'b00000, 10);
        check_int("t5_pulses", pulse_seen, 1);

        // Reset while UP is repeating, then a full re-debounce.
        hold(5'b00001, 130);
        period(5'b00001, 1'b1);
        pulse_seen = 0;
        hold(5'b00001, 6);
        check_int("t6_repress", pulse_seen, 1);
        hold(5'b00000, 8);
        pulse_seen = 0;
        hold(5'b00001, 10);
        hold(5'b00000, 8);
        check_int("t6_again", pulse_seen, 1);

        // Randomised segments of held patterns, glitches and occasional resets.
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 9);
            if (r < 5) pat = 5'(1 << $urandom_range(0, 4));
            else if (r < 7) pat = 5'b0;
            else pat = 5'($urandom_range(0, 31));
            len = ($urandom_range(0, 6) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 8);
            rst = ($urandom_range(0, 29) == 0);
            period(pat, rst);
            hold(pat, len - 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
